// File: rtl/mem_ctrl.sv
// Purpose: byte-serial RAM controller arbitrating store > load > fetch requests.
// Latency: grant 1 cycle; load result at pulse+n+2, store done at pulse+n+1 (n = bytes).
// Backpressure: one request held per port; pulses on a busy port are dropped; rdy low freezes all state.
//
// Ports:
//   clk, rst_n (synchronous, active-low), rdy (global enable), clear_flag_in (flush)
//   if_*  : instruction fetch request / completion (always 4 bytes)
//   lb_*  : load request (len 0=byte, 1=half, 3=word) / completion, data zero-extended
//   sb_*  : committed store request / completion pulse
//   mem_* : byte-wide RAM port; mem_din valid one cycle after mem_a
// Build option: define IO_BUFFER_STALL_EN to add io_buffer_full, which holds
//   store bytes aimed at 0x30000 / 0x30004 while it is high.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        clear_flag_in,
    input  logic        if_fetch_enable_in,
    input  logic [31:0] if_addr_in,
    output logic        if_result_enable_out,
    output logic [31:0] if_data_out,
    input  logic        lb_fetch_enable_in,
    input  logic [31:0] lb_addr_in,
    input  logic [1:0]  lb_len_in,
    output logic        lb_result_enable_out,
    output logic [31:0] lb_data_out,
    input  logic        sb_write_enable_in,
    input  logic [31:0] sb_addr_in,
    input  logic [1:0]  sb_len_in,
    input  logic [31:0] sb_data_in,
    output logic        sb_done_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
`ifdef IO_BUFFER_STALL_EN
    ,
    input  logic        io_buffer_full
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] PORT_IF = 2'd0;
    localparam logic [1:0] PORT_LB = 2'd1;
    localparam logic [1:0] PORT_SB = 2'd2;

    state_t      state;
    logic [1:0]  port;
    logic [2:0]  idx;       // READ: cycles elapsed (0..n); WRITE: byte being driven
    logic [2:0]  nbytes;
    logic [31:0] rd_buf;
    logic [31:0] rd_word;
    logic [1:0]  bsel;
    logic [23:0] wr_shift;  // remaining store bytes, next one in [7:0]
    logic        wr_q;
    logic        stall;

    logic        pend_if;
    logic [31:0] if_addr_q;
    logic        pend_lb;
    logic [31:0] lb_addr_q;
    logic [1:0]  lb_len_q;
    logic        pend_sb;
    logic [31:0] sb_addr_q;
    logic [1:0]  sb_len_q;
    logic [31:0] sb_data_q;

`ifdef IO_BUFFER_STALL_EN
    assign stall = (state == WRITE) && io_buffer_full &&
                   ((mem_a == 32'h0003_0000) || (mem_a == 32'h0003_0004));
`else
    assign stall = 1'b0;
`endif

    // The strobe is gated combinationally so a freeze or stall can never
    // repeat a write of the byte currently on the bus.
    assign mem_wr = wr_q & rdy & ~stall;

    // In READ cycle idx (idx >= 1) mem_din carries byte idx-1; merge it in.
    always_comb begin
        rd_word = rd_buf;
        bsel    = idx[1:0] - 2'd1;
        if (idx != 3'd0) begin
            rd_word[{bsel, 3'b000} +: 8] = mem_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= IDLE;
            port                 <= PORT_IF;
            idx                  <= 3'd0;
            nbytes               <= 3'd0;
            rd_buf               <= 32'd0;
            wr_shift             <= 24'd0;
            wr_q                 <= 1'b0;
            mem_a                <= 32'd0;
            mem_dout             <= 8'd0;
            pend_if              <= 1'b0;
            if_addr_q            <= 32'd0;
            pend_lb              <= 1'b0;
            lb_addr_q            <= 32'd0;
            lb_len_q             <= 2'd0;
            pend_sb              <= 1'b0;
            sb_addr_q            <= 32'd0;
            sb_len_q             <= 2'd0;
            sb_data_q            <= 32'd0;
            if_result_enable_out <= 1'b0;
            if_data_out          <= 32'd0;
            lb_result_enable_out <= 1'b0;
            lb_data_out          <= 32'd0;
            sb_done_out          <= 1'b0;
        end else if (rdy) begin
            if_result_enable_out <= 1'b0;
            lb_result_enable_out <= 1'b0;
            sb_done_out          <= 1'b0;

            // Request capture. A flush discards fetch/load work, including a
            // pulse arriving in the same cycle; stores are already committed.
            if (if_fetch_enable_in && !pend_if && !clear_flag_in) begin
                pend_if   <= 1'b1;
                if_addr_q <= if_addr_in;
            end else if (clear_flag_in) begin
                pend_if <= 1'b0;
            end

            if (lb_fetch_enable_in && !pend_lb && !clear_flag_in) begin
                pend_lb   <= 1'b1;
                lb_addr_q <= lb_addr_in;
                lb_len_q  <= lb_len_in;
            end else if (clear_flag_in) begin
                pend_lb <= 1'b0;
            end

            if (sb_write_enable_in && !pend_sb) begin
                pend_sb   <= 1'b1;
                sb_addr_q <= sb_addr_in;
                sb_len_q  <= sb_len_in;
                sb_data_q <= sb_data_in;
            end

            case (state)
                IDLE: begin
                    idx <= 3'd0;
                    if (pend_sb) begin
                        state    <= WRITE;
                        port     <= PORT_SB;
                        nbytes   <= {1'b0, sb_len_q} + 3'd1;
                        mem_a    <= sb_addr_q;
                        mem_dout <= sb_data_q[7:0];
                        wr_shift <= sb_data_q[31:8];
                        wr_q     <= 1'b1;
                    end else if (pend_lb && !clear_flag_in) begin
                        state  <= READ;
                        port   <= PORT_LB;
                        nbytes <= {1'b0, lb_len_q} + 3'd1;
                        mem_a  <= lb_addr_q;
                        rd_buf <= 32'd0;
                    end else if (pend_if && !clear_flag_in) begin
                        state  <= READ;
                        port   <= PORT_IF;
                        nbytes <= 3'd4;
                        mem_a  <= if_addr_q;
                        rd_buf <= 32'd0;
                    end
                end

                READ: begin
                    // Abort silently; the served port's pending bit is
                    // already dropped by the flush logic above.
                    if (clear_flag_in) begin
                        state <= IDLE;
                    end else begin
                        if (idx != 3'd0) begin
                            rd_buf <= rd_word;
                        end
                        if (idx == nbytes) begin
                            state <= DONE;
                            if (port == PORT_LB) begin
                                lb_data_out          <= rd_word;
                                lb_result_enable_out <= 1'b1;
                            end else begin
                                if_data_out          <= rd_word;
                                if_result_enable_out <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 3'd1;
                            if (idx < nbytes - 3'd1) begin
                                mem_a <= mem_a + 32'd1;
                            end
                        end
                    end
                end

                WRITE: begin
                    if (!stall) begin
                        if (idx == nbytes - 3'd1) begin
                            state       <= DONE;
                            wr_q        <= 1'b0;
                            sb_done_out <= 1'b1;
                        end else begin
                            idx      <= idx + 3'd1;
                            mem_a    <= mem_a + 32'd1;
                            mem_dout <= wr_shift[7:0];
                            wr_shift <= {8'h00, wr_shift[23:8]};
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    case (port)
                        PORT_SB: pend_sb <= 1'b0;
                        PORT_LB: pend_lb <= 1'b0;
                        default: pend_if <= 1'b0;
                    endcase
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 rdy  in  1  global enable; low freezes all state, mem_wr forced 0.
REQ-004 clear_flag_in  in  1  pipeline flush (mispredict).
REQ-005 if_fetch_enable_in / if_addr_in  in  1/32  instruction-fetch request pulse, word address.
REQ-006 if_result_enable_out / if_data_out  out  1/32  fetch-complete pulse, instruction word.
REQ-007 lb_fetch_enable_in / lb_addr_in / lb_len_in  in  1/32/2  load request pulse; len 0=byte, 1=half, 3=word.
REQ-008 lb_result_enable_out / lb_data_out  out  1/32  load-complete pulse, raw little-endian data, upper bytes zero.
REQ-009 sb_write_enable_in / sb_addr_in / sb_len_in / sb_data_in  in  1/32/2/32  committed-store request pulse.
REQ-010 sb_done_out  out  1  store-complete pulse.
REQ-011 mem_din  in  8  RAM read byte, valid one cycle after mem_a.
REQ-012 mem_dout / mem_a / mem_wr  out  8/32/1  RAM write byte, byte address, write strobe.

Function
REQ-013 Each port SHALL latch its request into a pending register on the enable pulse; a pulse arriving while that port is already pending or in service SHALL be ignored.
REQ-014 Arbiter in IDLE SHALL grant store > load > fetch; grant takes one cycle, first byte address driven the cycle after grant.
REQ-015 States: IDLE, READ, WRITE, DONE; IDLE->READ/WRITE on grant, READ/WRITE->DONE after last byte, DONE->IDLE after one cycle.
REQ-016 Byte count n = len+1 (fetch always 4); byte i at address base+i, i = 0..n-1, 32-bit wrap-around permitted.
REQ-017 READ: byte i address driven in cycle g+1+i, mem_din byte i captured into bits [8i+7:8i] in cycle g+2+i.
REQ-018 WRITE: mem_wr=1, mem_dout = sb_data_in byte i, mem_a = base+i in cycle g+1+i; mem_wr=0 in all other cycles.
REQ-019 Completion pulse (if/lb_result_enable_out or sb_done_out) SHALL be high exactly one cycle, in DONE; data outputs held until the next completion on that port.
REQ-020 Load latency from request pulse at edge t with immediate grant: result pulse in cycle t+n+2 (word: t+6); store done in cycle t+n+1.
REQ-021 clear_flag_in SHALL drop pending fetch and load requests and abort an in-service READ to IDLE next cycle with no completion pulse; pending or in-service stores SHALL be unaffected.
REQ-022 Request pulse coincident with clear_flag_in on the fetch or load port SHALL be discarded; on the store port, accepted.
REQ-023 Grant and a new request pulse on a different port in the same cycle SHALL both take effect.

Reset
REQ-024 rst_n low at an edge SHALL force state IDLE, all pending registers cleared, mem_wr=0, mem_a=0, mem_dout=0, all completion pulses 0, data outputs 0.
REQ-025 Reset mid-transaction SHALL abandon it silently, no completion pulse, no further write strobe.

Configuration
REQ-026 Macro IO_BUFFER_STALL_EN defined: extra input io_buffer_full (1 bit); a WRITE byte to address 0x30000 or 0x30004 SHALL be held (mem_wr=0, byte index frozen) while io_buffer_full is high.
REQ-027 Macro undefined: io_buffer_full port absent, no stall, all addresses written per REQ-018.

Verification
REQ-028 Word load addr 0x100, RAM 0x100..0x103 = 11,22,33,44 -> lb_result pulse at t+6, lb_data_out = 0x44332211.
REQ-029 Byte load addr 0x7 (RAM 0xF0) -> lb_data_out = 0x000000F0, pulse at t+3.
REQ-030 Fetch and store pulsed same cycle -> store writes 4 bytes first, sb_done_out, then fetch completes; never overlapping mem_wr with read.
REQ-031 Load in READ, clear_flag_in at second byte -> no lb_result pulse, state IDLE next cycle; concurrent pending store still completes.
REQ-032 Half store 0xABCD to 0xFFFFFFFF -> writes CD at 0xFFFFFFFF, AB at 0x0.
REQ-033 With IO_BUFFER_STALL_EN, byte store to 0x30000, io_buffer_full high 5 cycles -> mem_wr asserted only after io_buffer_full falls, sb_done_out follows.
